ram_loader: RTL

- Writer-side initiator for the 2048x32 block RAM: takes a byte stream (typically from the UART receiver), assembles big-endian 32-bit words and drives the RAM write port (en/we/addr/din).
- Sits between the UART rx path and RAM port A during program download.
- Frame format:
  - 4-byte start word address.
  - 4-byte word count N.
  - N data words, 4 bytes each, MSB first.
- Reports a running 32-bit checksum, a done pulse and a sticky error flag.

---
 rtl/ram_loader_pkg.sv | 17 +
 rtl/ram_loader_byte_packer.sv | 34 +++
 rtl/ram_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the UART-to-RAM program loader.
// Imported by ram_loader and byte_packer.
package ram_loader_pkg;

  localparam int DEF_ADDR_W     = 11;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR_ADDR,
    HDR_CNT,
    DATA,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/ram_loader_byte_packer.sv
// Collects bytes MSB first into a 32-bit word.
// word is combinational and valid alongside word_valid on the 4th byte.
module byte_packer
  import ram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  assign word       = {sr, byte_in};
  assign word_valid = take && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (clr) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (take) begin
      cnt <= cnt + 2'd1;
      sr  <= {sr[15:0], byte_in};
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Byte-stream frame loader driving the write port of the program RAM.
// Frame: start address, word count, then count big-endian words.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  localparam logic [32:0]     DEPTH = 33'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t state, state_n;

  logic              rdy_q;
  logic              fire;
  logic              pk_clr;
  logic [31:0]       word;
  logic              wv;
  logic [ADDR_W-1:0] addr_q;
  logic              hi_q;
  logic [ADDR_W:0]   rem_q;
  logic [32:0]       span;
  logic              hdr_bad;
  logic              done_n;
  logic              err_set;

  assign in_ready = rdy_q & en;
  assign fire     = in_valid & in_ready;
  assign pk_clr   = !en && (state != IDLE);

  byte_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .take       (fire),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (wv)
  );

  // 33-bit sum so a frame ending past the top cannot wrap to look legal
  assign span    = {{(33 - ADDR_W){1'b0}}, addr_q} + {1'b0, word};
  assign hdr_bad = ({1'b0, word} > DEPTH) || (span > DEPTH) || hi_q;

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_set = 1'b0;
    if (state != IDLE && !en) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) state_n = HDR_ADDR;
        end
        HDR_ADDR: begin
          if (wv) state_n = HDR_CNT;
        end
        HDR_CNT: begin
          if (wv) begin
            if (hdr_bad) begin
              err_set = 1'b1;
              state_n = IDLE;
            end else if (word == 32'd0) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = DATA;
            end
          end
        end
        DATA: begin
          if (wv) state_n = WRITE;
        end
        WRITE: begin
          state_n = (rem_q == ONE) ? DONE : DATA;
        end
        DONE: begin
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      checksum <= 32'd0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      addr_q   <= '0;
      hi_q     <= 1'b0;
      rem_q    <= '0;
    end else begin
      state  <= state_n;
      rdy_q  <= (state_n == IDLE) || (state_n == HDR_ADDR) ||
                (state_n == HDR_CNT) || (state_n == DATA);
      busy   <= (state_n != IDLE);
      done   <= done_n || (state_n == DONE);
      ram_en <= (state_n == WRITE);
      ram_we <= (state_n == WRITE);
      if (state == IDLE && fire) begin
        err      <= 1'b0;
        checksum <= 32'd0;
      end
      if (err_set) err <= 1'b1;
      if (state == HDR_ADDR && wv) begin
        addr_q <= word[ADDR_W-1:0];
        hi_q   <= |word[31:ADDR_W];
      end
      if (state == HDR_CNT && wv) rem_q <= word[ADDR_W:0];
      if (state == DATA && wv) begin
        ram_din  <= word[DATA_W-1:0];
        ram_addr <= addr_q;
      end
      // the write is committed even if en drops during WRITE
      if (state == WRITE) begin
        checksum <= checksum + 32'(ram_din);
        addr_q   <= addr_q + 1'b1;
        rem_q    <= rem_q - ONE;
      end
    end
  end

endmodule
